// File: rtl/serial_subtractor_unsigned.sv
// rtl/serial_subtractor_unsigned.sv - bit-serial unsigned subtractor, LSB first, ready/valid handshake
module serial_subtractor_unsigned #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Diff,
    output logic         Bout,
    output logic         V,
    output logic         Z
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic          borrow;
    logic [IW-1:0] idx;

    logic          a_bit;
    logic          b_bit;
    logic          d_bit;
    logic          borrow_next;
    logic [N-1:0]  diff_next;

    // One full-subtractor cell on the current LSBs of the operand shift registers
    always_comb begin
        a_bit       = a_sh[0];
        b_bit       = b_sh[0];
        d_bit       = a_bit ^ b_bit ^ borrow;
        borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
    end

    // Result bits enter at the MSB and shift down, so after N steps bit 0 holds the first bit computed
    if (N == 1) begin : g_one
        assign diff_next = d_bit;
    end else begin : g_many
        assign diff_next = {d_bit, Diff[N-1:1]};
    end

    // Control FSM and datapath: accept operands, ripple the borrow for N edges, hold result until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Diff      <= '0;
            Bout      <= 1'b0;
            V         <= 1'b0;
            Z         <= 1'b0;
            borrow    <= 1'b0;
            idx       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= A;
                        b_sh     <= B;
                        borrow   <= Bin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    Diff   <= diff_next;
                    borrow <= borrow_next;
                    if (idx == LAST) begin
                        Bout      <= borrow_next;
                        V         <= borrow_next;
                        Z         <= (diff_next == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
